probe_value_bank: RTL and testbench
===================================

Name: probe_value_bank

Overview:
- Multi-channel successor to the single-value probe.
- Watches NumProbes independent probe inputs and detects value changes on each one.
- Buffers each captured value in a per-channel FIFO.
- Ships captured values on the shared 32-bit uplink with round-robin arbitration between channels.
- Adds per-record sequence numbers, sticky overflow flags and FIFO-based DELAY back-pressure. It sits between design probes and the serial probe uplink.

Parameters:
- BaseId, 0: probe ID of channel 0; channel i uses BaseId+i (16-bit).
- NumProbes, 4: number of channels, 1..16.
- ProbeWidth, 1: width of each channel's value, 1..256.
- FifoDepth, 4: entries per channel FIFO; power of two, at least 2.
- InitiallyEnabled, 1'b0: enable state of every channel after reset.

Ports:
- UCLK  in  1  single clock for all logic.
- URST_N  in  1  asynchronous, active-low reset.
- CMDEN  in  1  command strobe.
- CMD  in  19  command: [18:3] probe ID, [2:0] opcode.
- PROBEIN  in  NumProbes*ProbeWidth  channel i occupies slice [i*ProbeWidth +: ProbeWidth].
- PROBEEN  in  NumProbes  per-channel sample qualifier.
- DATAUP  out  32  uplink word.
- DATAVALID  out  1  DATAUP holds a valid word.
- ACK  in  1  host consumes the current DATAUP word.
- DELAY  out  1  request to stall the emulation clock.
- OVERFLOW  out  NumProbes  sticky per-channel drop flag.

Behaviour:
- Derived value: ProbeWords = (ProbeWidth+31)/32.
- Reset (async): every output is 0; enabled = InitiallyEnabled; last-value registers, FIFOs, sequence counters, OVERFLOW and the serializer all clear. A reset during a transfer abandons the record; DATAVALID is low after the reset is released.
- Command decode: a command addresses channel i when CMDEN=1 and CMD[18:3] == BaseId+i. IDs outside the range are ignored. Effects are visible after the edge.
  - 3'd2 PENABLE: enable the channel and force one push of its current last value, even if unchanged.
  - 3'd5 PSENDONCE: enable the channel; it auto-disables after its next push.
  - 3'd3 PCLEAROVF: clear OVERFLOW[i]; the enable state is unchanged.
  - Any other opcode: disable the channel and flush its FIFO. A record already loaded in the serializer still completes.
- Capture, per channel, on each edge:
  - change = PROBEEN[i] && slice != last[i].
  - On change: last[i] <= slice.
  - If the channel is enabled and (change or forced), push the value.
  - The push uses the new slice on a change, otherwise last[i].
  - If the FIFO is full and there is no pop this cycle, drop the value and set OVERFLOW[i].
  - A push and pop in the same cycle are legal when full.
  - A command arriving in the same cycle as a change: the change is judged against the old enable state.
- Arbiter/serializer FSM with states IDLE, HDR, DATA:
  - IDLE: choose the lowest index at or after rr_ptr, wrapping, whose FIFO is non-empty. Pop it, load the header and go to HDR. Set rr_ptr to the winner+1, wrapping NumProbes-1 -> 0.
  - Header word = {BaseId+i[15:0], seq[i][7:0], ProbeWords[7:0]}. seq[i] increments after each load and wraps 255 -> 0.
  - HDR/DATA: DATAVALID=1. DATAUP changes only on an edge where ACK=1.
  - Each ACK advances to the next data word, 32 bits at a time, LSB first. Unused upper bits of the last word are 0.
  - The ACK of the final data word returns to IDLE with DATAVALID=0 for exactly one cycle.
  - ACK while in IDLE is ignored.
- Latency: a value captured at edge E0 gives DATAVALID=1 with the header after E1, provided the serializer is idle and the channel wins arbitration.
- DELAY = OR over enabled channels of (FIFO count >= FifoDepth-1). It is combinational from registered state.

Decomposition:
- Package probe_pkg holds:
  - opcode constants PENABLE=2, PCLEAROVF=3, PSENDONCE=5;
  - a ProbeWords function;
  - a header-packing function;
  - the serializer state enum.
- Sub-module probe_chan_fifo holds one channel's change detection, enable/sendonce/forced flags, FIFO, count and overflow flag. The top level instantiates NumProbes of them with a generate loop and adds the round-robin arbiter and the serializer.

Test Plan:
- Change and latency (NumProbes=4, ProbeWidth=8, BaseId=16): enable channel 1, drive 0x5A with PROBEEN=1, hold ACK=1. Required: header 0x0011_0001 then data 0x0000_005A; DATAVALID goes low for one cycle; next record from channel 1 carries seq 1.
- Multi-word (ProbeWidth=40): value 0xAB_1234_5678. Required: header, then 0x1234_5678, then 0x0000_00AB; DATAUP holds while ACK=0.
- Round-robin: channels 0, 2 and 3 change in the same cycle with rr_ptr=1. Required: records are emitted in the order 2, 3, 0.
- Overflow: FifoDepth=4, ACK=0, six changes on channel 0. Required: DELAY rises after the third push; OVERFLOW[0]=1 after the fifth change; PCLEAROVF clears it; the values drained are the first four.
- Sendonce/forced: PSENDONCE on channel 2 followed by two changes. Required: exactly one record, and the channel reads back as disabled. PENABLE with no change produces one record holding the current value.
- Reset mid-record: assert URST_N=0 while in DATA. Required: DATAVALID, DATAUP, OVERFLOW and seq are 0 immediately; there are no records after release until a new change occurs.

Source files
------------

// File: rtl/probe_pkg.sv
// probe_pkg: shared opcodes, serializer states and header helpers for the probe value bank.
package probe_pkg;

    localparam logic [2:0] PENABLE   = 3'd2;
    localparam logic [2:0] PCLEAROVF = 3'd3;
    localparam logic [2:0] PSENDONCE = 3'd5;

    typedef enum logic [1:0] {IDLE, HDR, DATA} ser_state_t;

    function automatic int probe_words(input int width);
        return (width + 31) / 32;
    endfunction

    function automatic logic [31:0] pack_header(input logic [15:0] id, input logic [7:0] seq,
                                                input logic [7:0] words);
        return {id, seq, words};
    endfunction

endpackage

// File: rtl/probe_chan_fifo.sv
// probe_chan_fifo: one probe channel - change detection, enable/sendonce/forced flags,
// value FIFO with occupancy count and sticky overflow flag.
module probe_chan_fifo
    import probe_pkg::*;
#(
    parameter int ProbeWidth       = 1,
    parameter int FifoDepth        = 4,
    parameter bit InitiallyEnabled = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd,
    input  logic [2:0]            i_op,
    input  logic [ProbeWidth-1:0] i_probe,
    input  logic                  i_probeen,
    input  logic                  i_pop,
    output logic [ProbeWidth-1:0] o_data,
    output logic                  o_empty,
    output logic                  o_delay,
    output logic                  o_overflow
);

    localparam int AW = $clog2(FifoDepth);
    localparam int CW = AW + 1;

    logic [ProbeWidth-1:0] r_mem [FifoDepth];
    logic [ProbeWidth-1:0] r_last;
    logic [AW-1:0]         r_wr, r_rd;
    logic [CW-1:0]         r_cnt;
    logic                  r_en, r_once, r_force, r_ovf;
    logic                  w_change, w_req, w_full, w_drop, w_push;
    logic [ProbeWidth-1:0] w_val;

    assign w_change   = i_probeen && (i_probe != r_last);
    assign w_req      = r_en && (w_change || r_force);
    assign w_val      = w_change ? i_probe : r_last;
    assign w_full     = r_cnt == CW'(FifoDepth);
    assign w_drop     = w_req && w_full && !i_pop;
    assign w_push     = w_req && !w_drop;
    assign o_data     = r_mem[r_rd];
    assign o_empty    = r_cnt == '0;
    assign o_delay    = r_en && (r_cnt >= CW'(FifoDepth - 1));
    assign o_overflow = r_ovf;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= w_val;
    end

    // Capture is judged on the old enable state; a command in the same cycle then overrides flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last  <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_en    <= InitiallyEnabled;
            r_once  <= 1'b0;
            r_force <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_change) r_last <= i_probe;
            if (w_push) r_wr <= r_wr + AW'(1);
            if (i_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(i_pop);
            if (w_drop) r_ovf <= 1'b1;
            if (w_req) begin
                r_force <= 1'b0;
                if (r_once) begin
                    r_en   <= 1'b0;
                    r_once <= 1'b0;
                end
            end
            if (i_cmd) begin
                if (i_op == PENABLE) begin
                    r_en    <= 1'b1;
                    r_force <= 1'b1;
                end else if (i_op == PSENDONCE) begin
                    r_en   <= 1'b1;
                    r_once <= 1'b1;
                end else if (i_op == PCLEAROVF) begin
                    r_ovf <= 1'b0;
                end else begin
                    r_en    <= 1'b0;
                    r_once  <= 1'b0;
                    r_force <= 1'b0;
                    r_wr    <= '0;
                    r_rd    <= '0;
                    r_cnt   <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/probe_value_bank.sv
// probe_value_bank: multi-channel value probe; per-channel change FIFOs drained onto a
// shared 32-bit uplink by a round-robin arbiter and header/data serializer.
module probe_value_bank
    import probe_pkg::*;
#(
    parameter logic [15:0] BaseId           = 16'd0,
    parameter int          NumProbes        = 4,
    parameter int          ProbeWidth       = 1,
    parameter int          FifoDepth        = 4,
    parameter bit          InitiallyEnabled = 1'b0
) (
    input  logic                            UCLK,
    input  logic                            URST_N,
    input  logic                            CMDEN,
    input  logic [18:0]                     CMD,
    input  logic [NumProbes*ProbeWidth-1:0] PROBEIN,
    input  logic [NumProbes-1:0]            PROBEEN,
    output logic [31:0]                     DATAUP,
    output logic                            DATAVALID,
    input  logic                            ACK,
    output logic                            DELAY,
    output logic [NumProbes-1:0]            OVERFLOW
);

    localparam int PW = probe_words(ProbeWidth);
    localparam int SW = PW * 32;
    localparam int IW = NumProbes > 1 ? $clog2(NumProbes) : 1;

    logic [NumProbes-1:0]  w_empty, w_pop, w_delay;
    logic [ProbeWidth-1:0] w_data [NumProbes];
    logic                  w_any;
    logic [IW-1:0]         w_win, w_idx;
    ser_state_t            r_state;
    logic [IW-1:0]         r_rr;
    logic [7:0]            r_seq [NumProbes];
    logic [SW-1:0]         r_shift;
    logic [7:0]            r_left;

    genvar i;
    generate
        for (i = 0; i < NumProbes; i++) begin : g_chan
            localparam logic [15:0] ID = BaseId + 16'(i);
            probe_chan_fifo #(
                .ProbeWidth      (ProbeWidth),
                .FifoDepth       (FifoDepth),
                .InitiallyEnabled(InitiallyEnabled)
            ) u_chan (
                .i_clk     (UCLK),
                .i_rst_n   (URST_N),
                .i_cmd     (CMDEN && (CMD[18:3] == ID)),
                .i_op      (CMD[2:0]),
                .i_probe   (PROBEIN[i*ProbeWidth +: ProbeWidth]),
                .i_probeen (PROBEEN[i]),
                .i_pop     (w_pop[i]),
                .o_data    (w_data[i]),
                .o_empty   (w_empty[i]),
                .o_delay   (w_delay[i]),
                .o_overflow(OVERFLOW[i])
            );
            assign w_pop[i] = (r_state == IDLE) && w_any && (w_win == IW'(i));
        end
    endgenerate

    assign DELAY = |w_delay;

    // Scan from the far end so the nearest non-empty channel at or after r_rr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = NumProbes - 1; k >= 0; k--) begin
            w_idx = IW'((int'(r_rr) + k) % NumProbes);
            if (!w_empty[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    always_ff @(posedge UCLK or negedge URST_N) begin
        if (!URST_N) begin
            r_state   <= IDLE;
            r_rr      <= '0;
            r_shift   <= '0;
            r_left    <= '0;
            DATAUP    <= '0;
            DATAVALID <= 1'b0;
            for (int n = 0; n < NumProbes; n++) r_seq[n] <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    DATAUP       <= pack_header(BaseId + 16'(w_win), r_seq[w_win], 8'(PW));
                    DATAVALID    <= 1'b1;
                    r_shift      <= SW'(w_data[w_win]);
                    r_left       <= 8'(PW - 1);
                    r_seq[w_win] <= r_seq[w_win] + 8'd1;
                    r_rr         <= (w_win == IW'(NumProbes - 1)) ? '0 : w_win + IW'(1);
                    r_state      <= HDR;
                end
                HDR: if (ACK) begin
                    DATAUP  <= r_shift[31:0];
                    r_shift <= r_shift >> 32;
                    r_state <= DATA;
                end
                DATA: if (ACK) begin
                    if (r_left == 8'd0) begin
                        DATAUP    <= '0;
                        DATAVALID <= 1'b0;
                        r_state   <= IDLE;
                    end else begin
                        DATAUP  <= r_shift[31:0];
                        r_shift <= r_shift >> 32;
                        r_left  <= r_left - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_probe_value_bank.sv
// tb_probe_value_bank: directed stimulus against a queue-based model of the probe bank,
// compared every cycle, plus literal expectations for headers, data and flags.
module tb_probe_value_bank;

    localparam int N     = 4;
    localparam int W     = 40;
    localparam int BASE  = 16;
    localparam int DEPTH = 4;
    localparam int WORDS = (W + 31) / 32;
    localparam logic [2:0] OP_EN = 3'd2, OP_CLR = 3'd3, OP_ONCE = 3'd5;

    logic           UCLK = 1'b0;
    logic           URST_N, CMDEN, ACK, DATAVALID, DELAY;
    logic [18:0]    CMD;
    logic [N*W-1:0] PROBEIN;
    logic [N-1:0]   PROBEEN, OVERFLOW;
    logic [31:0]    DATAUP;

    probe_value_bank #(
        .BaseId(16'd16), .NumProbes(N), .ProbeWidth(W), .FifoDepth(DEPTH), .InitiallyEnabled(1'b0)
    ) dut (
        .UCLK(UCLK), .URST_N(URST_N), .CMDEN(CMDEN), .CMD(CMD), .PROBEIN(PROBEIN),
        .PROBEEN(PROBEEN), .DATAUP(DATAUP), .DATAVALID(DATAVALID), .ACK(ACK),
        .DELAY(DELAY), .OVERFLOW(OVERFLOW)
    );

    always #5 UCLK = ~UCLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per-channel flags and value queues, plus the record currently on the uplink.
    logic [W-1:0]  m_last [N];
    bit            m_en [N], m_so [N], m_fc [N], m_ovf [N];
    logic [W-1:0]  m_q [N][$];
    int            m_seq [N];
    int            m_rr, m_idx;
    bit            m_busy;
    logic [31:0]   m_rec [$];
    logic [31:0]   got [$];

    always @(posedge UCLK or negedge URST_N) begin
        logic [W-1:0] s, v;
        bit chg, pen, found;
        int c;
        if (!URST_N) begin
            for (int i = 0; i < N; i++) begin
                m_last[i] = '0; m_en[i] = 0; m_so[i] = 0; m_fc[i] = 0; m_ovf[i] = 0;
                m_q[i].delete(); m_seq[i] = 0;
            end
            m_rr = 0; m_busy = 0; m_idx = 0; m_rec.delete();
        end else begin
            if (!m_busy) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    c = (m_rr + k) % N;
                    if (!found && m_q[c].size() > 0) begin
                        found = 1;
                        v = m_q[c].pop_front();
                        m_rec.delete();
                        m_rec.push_back({16'(BASE + c), 8'(m_seq[c]), 8'(WORDS)});
                        for (int w = 0; w < WORDS; w++) m_rec.push_back(32'(v >> (32 * w)));
                        m_seq[c] = (m_seq[c] + 1) % 256;
                        m_rr = (c + 1) % N;
                        m_busy = 1;
                        m_idx = 0;
                    end
                end
            end else if (ACK) begin
                m_idx++;
                if (m_idx == m_rec.size()) m_busy = 0;
            end
            for (int i = 0; i < N; i++) begin
                s = PROBEIN[i*W +: W];
                chg = PROBEEN[i] && (s != m_last[i]);
                pen = m_en[i] && (chg || m_fc[i]);
                if (chg) m_last[i] = s;
                if (pen) begin
                    m_fc[i] = 0;
                    if (m_q[i].size() == DEPTH) m_ovf[i] = 1;
                    else m_q[i].push_back(m_last[i]);
                    if (m_so[i]) begin m_en[i] = 0; m_so[i] = 0; end
                end
            end
            c = int'(CMD[18:3]) - BASE;
            if (CMDEN && c >= 0 && c < N) begin
                case (CMD[2:0])
                    OP_EN:   begin m_en[c] = 1; m_fc[c] = 1; end
                    OP_ONCE: begin m_en[c] = 1; m_so[c] = 1; end
                    OP_CLR:  m_ovf[c] = 0;
                    default: begin m_en[c] = 0; m_so[c] = 0; m_fc[c] = 0; m_q[c].delete(); end
                endcase
            end
        end
    end

    always @(negedge UCLK) begin
        logic [N-1:0] ov;
        logic dl;
        ov = '0;
        dl = 1'b0;
        for (int i = 0; i < N; i++) begin
            ov[i] = m_ovf[i];
            if (m_en[i] && m_q[i].size() >= DEPTH - 1) dl = 1'b1;
        end
        check("cyc_datavalid", 32'(DATAVALID), 32'(m_busy));
        if (m_busy) check("cyc_dataup", DATAUP, m_rec[m_idx]);
        check("cyc_delay", 32'(DELAY), 32'(dl));
        check("cyc_overflow", 32'(OVERFLOW), 32'(ov));
        if (DATAVALID && ACK) got.push_back(DATAUP);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge UCLK);
            #2;
        end
    endtask

    task automatic cmd(input logic [15:0] id, input logic [2:0] op);
        CMDEN = 1'b1;
        CMD   = {id, op};
        step();
        CMDEN = 1'b0;
    endtask

    task automatic setp(input int c, input logic [W-1:0] v);
        PROBEIN[c*W +: W] = v;
    endtask

    initial begin
        URST_N = 1'b0; CMDEN = 1'b0; CMD = '0; PROBEIN = '0; PROBEEN = '1; ACK = 1'b0;
        step(2);
        URST_N = 1'b1;
        check("rst_datavalid", 32'(DATAVALID), 32'd0);
        check("rst_dataup", DATAUP, 32'd0);
        check("rst_overflow", 32'(OVERFLOW), 32'd0);
        check("rst_delay", 32'(DELAY), 32'd0);

        // Enable and change in the same edge: change judged disabled, then forced push.
        ACK = 1'b1;
        setp(1, 40'h5A);
        cmd(16'd17, OP_EN);
        check("en_no_push_yet", 32'(DATAVALID), 32'd0);
        step();
        check("forced_push_lat", 32'(DATAVALID), 32'd0);
        step();
        check("hdr_ch1_seq0", DATAUP, 32'h0011_0002);
        step();
        check("data_5a", DATAUP, 32'h0000_005A);
        step();
        check("data_5a_hi", DATAUP, 32'h0000_0000);
        step();
        check("idle_after_rec", 32'(DATAVALID), 32'd0);
        setp(1, 40'h77);
        step();
        check("lat_e0", 32'(DATAVALID), 32'd0);
        step();
        check("lat_e1_valid", 32'(DATAVALID), 32'd1);
        check("hdr_ch1_seq1", DATAUP, 32'h0011_0102);
        step(3);
        check("idle_after_77", 32'(DATAVALID), 32'd0);
        check("got_77", got[got.size()-2], 32'h0000_0077);

        // Multi-word record with hold while ACK is low.
        ACK = 1'b0;
        setp(1, 40'hAB_1234_5678);
        step(2);
        check("mw_hdr", DATAUP, 32'h0011_0202);
        step(3);
        check("mw_hdr_hold", DATAUP, 32'h0011_0202);
        ACK = 1'b1;
        step();
        check("mw_w0", DATAUP, 32'h1234_5678);
        ACK = 1'b0;
        step(2);
        check("mw_w0_hold", DATAUP, 32'h1234_5678);
        ACK = 1'b1;
        step();
        check("mw_w1", DATAUP, 32'h0000_00AB);
        step();
        check("mw_done", 32'(DATAVALID), 32'd0);

        // Round robin: leave rr_ptr at 1, then change 0, 2, 3 together.
        cmd(16'd16, OP_EN);
        cmd(16'd18, OP_EN);
        cmd(16'd19, OP_EN);
        step(20);
        setp(0, 40'h01);
        step(10);
        got.delete();
        setp(0, 40'h100);
        setp(2, 40'h200);
        setp(3, 40'h300);
        step(15);
        check("rr_count", got.size(), 32'd9);
        if (got.size() == 9) begin
            check("rr_first_ch2", got[0], 32'h0012_0102);
            check("rr_first_val", got[1], 32'h0000_0200);
            check("rr_second_ch3", got[3], 32'h0013_0102);
            check("rr_second_val", got[4], 32'h0000_0300);
            check("rr_third_ch0", got[6], 32'h0010_0202);
            check("rr_third_val", got[7], 32'h0000_0100);
        end

        // Overflow: serializer held on a channel 1 record, six changes on channel 0.
        ACK = 1'b0;
        setp(1, 40'h99);
        step(2);
        check("ovf_hold_hdr", DATAUP, 32'h0011_0302);
        for (int k = 1; k <= 6; k++) begin
            setp(0, 40'h10 + 40'(k));
            step();
            if (k == 2) check("delay_after_2", 32'(DELAY), 32'd0);
            if (k == 3) check("delay_after_3", 32'(DELAY), 32'd1);
            if (k == 4) check("ovf_after_4", 32'(OVERFLOW), 32'd0);
            if (k == 5) check("ovf_after_5", 32'(OVERFLOW), 32'd1);
        end
        cmd(16'd16, OP_CLR);
        check("ovf_cleared", 32'(OVERFLOW), 32'd0);
        got.delete();
        ACK = 1'b1;
        step(22);
        check("drain_count", got.size(), 32'd15);
        if (got.size() == 15) begin
            check("drain_ch1", got[1], 32'h0000_0099);
            for (int k = 0; k < 4; k++) begin
                check("drain_hdr", got[3 + 3*k], {16'h0010, 8'(3 + k), 8'h02});
                check("drain_val", got[4 + 3*k], 32'h10 + 32'(k + 1));
            end
        end

        // Send-once then forced enable on channel 2.
        got.delete();
        cmd(16'd18, OP_ONCE);
        setp(2, 40'h21);
        step();
        setp(2, 40'h22);
        step(16);
        check("once_count", got.size(), 32'd3);
        check("once_hdr", got[0], 32'h0012_0202);
        check("once_val", got[1], 32'h0000_0021);
        setp(2, 40'h23);
        step(10);
        check("once_disabled", got.size(), 32'd3);
        got.delete();
        cmd(16'd18, OP_EN);
        step(10);
        check("force_count", got.size(), 32'd3);
        check("force_hdr", got[0], 32'h0012_0302);
        check("force_val", got[1], 32'h0000_0023);

        // Reset in the middle of a record, with channel 3 overflowed.
        got.delete();
        ACK = 1'b0;
        setp(1, 40'h55);
        step(2);
        check("pre_rst_hdr", DATAUP, 32'h0011_0402);
        ACK = 1'b1;
        step();
        ACK = 1'b0;
        check("pre_rst_data", DATAUP, 32'h0000_0055);
        for (int k = 1; k <= 5; k++) begin
            setp(3, 40'h30 + 40'(k));
            step();
        end
        check("pre_rst_ovf", 32'(OVERFLOW), 32'h8);
        URST_N = 1'b0;
        #1;
        check("rst_mid_dv", 32'(DATAVALID), 32'd0);
        check("rst_mid_dataup", DATAUP, 32'd0);
        check("rst_mid_ovf", 32'(OVERFLOW), 32'd0);
        check("rst_mid_delay", 32'(DELAY), 32'd0);
        step(2);
        URST_N = 1'b1;
        got.delete();
        ACK = 1'b1;
        step(10);
        check("post_rst_quiet", got.size(), 32'd0);
        cmd(16'd17, OP_EN);
        step(10);
        check("post_rst_count", got.size(), 32'd3);
        check("post_rst_seq0", got[0], 32'h0011_0002);
        check("post_rst_val", got[1], 32'h0000_0055);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
